// File: rtl/fd_fetch.sv
// fd_fetch -- circle-fetch sequencer for the FAST-9 detector datapath.
//
// Given a center pixel (centerX, centerY) it issues 17 SRAM reads: the
// center pixel (index 0) followed by the 16 radius-3 Bresenham circle
// pixels (index 1..16). The pixel register file is written one cycle
// later, when the SRAM data comes back. readen rises once all 17 entries
// are loaded.
//
// Optional feature: define FD_FETCH_BORDER_CHECK_EN to reject centers
// whose circle would leave the image. A rejected start pulses error.
// Without the macro every start is accepted and addresses simply wrap
// at ADDR_W bits.
//
// Ports:
//   clock     in   system clock
//   nReset    in   asynchronous active-low reset
//   start     in   fetch request, honoured in IDLE or VALID only
//   centerX   in   center column (8 bits)
//   centerY   in   center row (8 bits)
//   busy      out  fetch in progress (ISSUE or DRAIN)
//   sramAddr  out  SRAM read address (ADDR_W bits)
//   sramRe    out  SRAM read enable
//   regAddr   out  register-file index 0..16
//   regWe     out  register-file write strobe, aligned with SRAM data
//   readen    out  all 17 entries valid
//   done      out  one-cycle completion pulse
//   error     out  one-cycle pulse on a rejected center

module fd_fetch #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [7:0]        centerX,
  input  logic [7:0]        centerY,
  output logic              busy,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              sramRe,
  output logic [4:0]        regAddr,
  output logic              regWe,
  output logic              readen,
  output logic              done,
  output logic              error
);

  // The image must fit in the addressable SRAM.
  if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_size_check
    $error("fd_fetch: IMG_W*IMG_H exceeds SRAM address space");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, VALID} state_t;

  state_t     state;
  logic [4:0] idx;       // index of the read currently on sramAddr
  logic [7:0] cx;        // center latched at the accepted start
  logic [7:0] cy;
  logic [4:0] idx_next;

  assign idx_next = idx + 5'd1;

  // Row-major address of circle pixel k around (x, y). The sum is formed
  // in 32 bits and truncated, which equals computing modulo 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x,
                                                 input logic [7:0] y,
                                                 input logic [4:0] k);
    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic [31:0]       a;
    case (k)
      5'd1:    begin dx =  3'sd0; dy = -3'sd3; end
      5'd2:    begin dx =  3'sd1; dy = -3'sd3; end
      5'd3:    begin dx =  3'sd2; dy = -3'sd2; end
      5'd4:    begin dx =  3'sd3; dy = -3'sd1; end
      5'd5:    begin dx =  3'sd3; dy =  3'sd0; end
      5'd6:    begin dx =  3'sd3; dy =  3'sd1; end
      5'd7:    begin dx =  3'sd2; dy =  3'sd2; end
      5'd8:    begin dx =  3'sd1; dy =  3'sd3; end
      5'd9:    begin dx =  3'sd0; dy =  3'sd3; end
      5'd10:   begin dx = -3'sd1; dy =  3'sd3; end
      5'd11:   begin dx = -3'sd2; dy =  3'sd2; end
      5'd12:   begin dx = -3'sd3; dy =  3'sd1; end
      5'd13:   begin dx = -3'sd3; dy =  3'sd0; end
      5'd14:   begin dx = -3'sd3; dy = -3'sd1; end
      5'd15:   begin dx = -3'sd2; dy = -3'sd2; end
      5'd16:   begin dx = -3'sd1; dy = -3'sd3; end
      default: begin dx =  3'sd0; dy =  3'sd0; end
    endcase
    a = ({24'd0, y} + {{29{dy[2]}}, dy}) * 32'(IMG_W)
      + {24'd0, x} + {{29{dx[2]}}, dx};
    return a[ADDR_W-1:0];
  endfunction

`ifdef FD_FETCH_BORDER_CHECK_EN
  logic in_range;
  assign in_range = (int'(centerX) >= 3) && (int'(centerX) <= IMG_W - 4) &&
                    (int'(centerY) >= 3) && (int'(centerY) <= IMG_H - 4);
`endif

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      idx      <= 5'd0;
      cx       <= 8'd0;
      cy       <= 8'd0;
      busy     <= 1'b0;
      sramAddr <= '0;
      sramRe   <= 1'b0;
      regAddr  <= 5'd0;
      regWe    <= 1'b0;
      readen   <= 1'b0;
      done     <= 1'b0;
`ifdef FD_FETCH_BORDER_CHECK_EN
      error    <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
`ifdef FD_FETCH_BORDER_CHECK_EN
      error <= 1'b0;
`endif
      // Register-file write side trails the read side by the fixed
      // one-cycle SRAM latency; regAddr only moves on write beats.
      regWe <= sramRe;
      if (sramRe) begin
        regAddr <= idx;
      end

      case (state)
        IDLE, VALID: begin
          if (start) begin
`ifdef FD_FETCH_BORDER_CHECK_EN
            if (in_range) begin
`endif
              state    <= ISSUE;
              cx       <= centerX;
              cy       <= centerY;
              idx      <= 5'd0;
              sramRe   <= 1'b1;
              sramAddr <= pix_addr(centerX, centerY, 5'd0);
              busy     <= 1'b1;
              readen   <= 1'b0;
`ifdef FD_FETCH_BORDER_CHECK_EN
            end else begin
              state  <= IDLE;
              error  <= 1'b1;
              readen <= 1'b0;
            end
`endif
          end
        end
        ISSUE: begin
          if (idx == 5'd16) begin
            state  <= DRAIN;
            sramRe <= 1'b0;
          end else begin
            idx      <= idx_next;
            sramAddr <= pix_addr(cx, cy, idx_next);
          end
        end
        DRAIN: begin
          // Last write beat is on the bus this cycle.
          state  <= VALID;
          busy   <= 1'b0;
          readen <= 1'b1;
          done   <= 1'b1;
        end
      endcase
    end
  end

`ifndef FD_FETCH_BORDER_CHECK_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fd_fetch.sv
module tb_fd_fetch;

  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              nReset;
  logic              start;
  logic [7:0]        centerX;
  logic [7:0]        centerY;
  logic              busy;
  logic [ADDR_W-1:0] sramAddr;
  logic              sramRe;
  logic [4:0]        regAddr;
  logic              regWe;
  logic              readen;
  logic              done;
  logic              error;

  fd_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .nReset(nReset), .start(start),
    .centerX(centerX), .centerY(centerY),
    .busy(busy), .sramAddr(sramAddr), .sramRe(sramRe),
    .regAddr(regAddr), .regWe(regWe), .readen(readen),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // SRAM model: one-cycle read latency, data = low byte of the address.
  logic [7:0] rdata = 8'd0;
  always @(posedge clock) begin
    if (sramRe) rdata <= sramAddr[7:0];
  end

  int n_chk  = 0;
  int n_fail = 0;
  int obs_addr [17];

  // Circle offsets as listed for indices 0..16.
  int DX [17] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int DY [17] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  function automatic int ref_addr(input int x, input int y, input int k);
    return ((y + DY[k]) * IMG_W + x + DX[k]) & ((1 << ADDR_W) - 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Full 19-cycle fetch, every output compared every cycle against the model.
  task automatic do_fetch(input int x, input int y, input bit jitter, input bit extra);
    int writes;
    writes  = 0;
    centerX = 8'(x);
    centerY = 8'(y);
    start   = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clock);
      chk($sformatf("busy T%0d", k), int'(busy), int'(k <= 18));
      chk($sformatf("sramRe T%0d", k), int'(sramRe), int'(k <= 17));
      if (k <= 17) begin
        chk($sformatf("sramAddr idx%0d (%0d,%0d)", k - 1, x, y),
            int'(sramAddr), ref_addr(x, y, k - 1));
        obs_addr[k-1] = int'(sramAddr);
      end
      chk($sformatf("regWe T%0d", k), int'(regWe), int'(k >= 2 && k <= 18));
      if (regWe) writes++;
      if (k >= 2 && k <= 18) begin
        chk($sformatf("regAddr T%0d", k), int'(regAddr), k - 2);
        chk($sformatf("wdata idx%0d", k - 2), int'(rdata), ref_addr(x, y, k - 2) & 255);
      end
      chk($sformatf("done T%0d", k), int'(done), int'(k == 19));
      chk($sformatf("readen T%0d", k), int'(readen), int'(k == 19));
      chk($sformatf("error T%0d", k), int'(error), 0);
      if (jitter) begin
        centerX = 8'($urandom);
        centerY = 8'($urandom);
      end
      if (extra && (k == 5 || k == 10)) begin
        centerX = 8'($urandom_range(3, 60));
        centerY = 8'($urandom_range(3, 60));
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("write beats", writes, 17);
    $display("fetch (%0d,%0d): first addr %0d, %0d writes", x, y, obs_addr[0], writes);
  endtask

  task automatic idle_cycles(input int n, input bit exp_readen);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle busy", int'(busy), 0);
      chk("idle sramRe", int'(sramRe), 0);
      chk("idle regWe", int'(regWe), 0);
      chk("idle done", int'(done), 0);
      chk("idle readen", int'(readen), int'(exp_readen));
    end
    $display("idle %0d cycles, readen %0d", n, exp_readen);
  endtask

`ifdef FD_FETCH_BORDER_CHECK_EN
  task automatic reject(input int x, input int y);
    centerX = 8'(x);
    centerY = 8'(y);
    start   = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    chk("reject error T1", int'(error), 1);
    chk("reject sramRe T1", int'(sramRe), 0);
    chk("reject busy T1", int'(busy), 0);
    chk("reject readen T1", int'(readen), 0);
    @(negedge clock);
    chk("reject error T2", int'(error), 0);
    chk("reject sramRe T2", int'(sramRe), 0);
    chk("reject regWe T2", int'(regWe), 0);
    $display("reject (%0d,%0d)", x, y);
  endtask
`endif

  typedef struct {
    int x;
    int y;
    int idx;
    int addr;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int lx, ly;
    // Addresses hand-derived for IMG_W = 64.
    tbl[0]  = '{10, 10, 0, 650};
    tbl[1]  = '{10, 10, 1, 458};
    tbl[2]  = '{10, 10, 4, 589};
    tbl[3]  = '{10, 10, 5, 653};
    tbl[4]  = '{10, 10, 8, 843};
    tbl[5]  = '{10, 10, 9, 842};
    tbl[6]  = '{10, 10, 12, 711};
    tbl[7]  = '{10, 10, 13, 647};
    tbl[8]  = '{10, 10, 16, 457};
    tbl[9]  = '{30, 30, 0, 1950};
    tbl[10] = '{60, 60, 0, 3900};
    tbl[11] = '{60, 60, 4, 3839};

    nReset  = 1'b0;
    start   = 1'b0;
    centerX = 8'd0;
    centerY = 8'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset busy", int'(busy), 0);
    chk("reset sramRe", int'(sramRe), 0);
    chk("reset sramAddr", int'(sramAddr), 0);
    chk("reset regWe", int'(regWe), 0);
    chk("reset regAddr", int'(regAddr), 0);
    chk("reset readen", int'(readen), 0);
    chk("reset done", int'(done), 0);
    chk("reset error", int'(error), 0);
    $display("reset checked");
    nReset = 1'b1;
    @(negedge clock);

    // Table vectors; consecutive fetches start in the first VALID cycle.
    lx = -1;
    ly = -1;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].x != lx || tbl[i].y != ly) begin
        do_fetch(tbl[i].x, tbl[i].y, 1'b0, 1'b0);
        lx = tbl[i].x;
        ly = tbl[i].y;
      end
      chk($sformatf("table %0d", i), obs_addr[tbl[i].idx], tbl[i].addr);
    end

    // Starts during ISSUE are ignored, readen then holds.
    do_fetch(10, 10, 1'b1, 1'b1);
    idle_cycles(20, 1'b1);

`ifdef FD_FETCH_BORDER_CHECK_EN
    reject(2, 10);
    idle_cycles(3, 1'b0);
    reject(10, 61);
    do_fetch(60, 60, 1'b0, 1'b0);
    reject(61, 30);
`else
    do_fetch(2, 10, 1'b0, 1'b0);
    do_fetch(0, 0, 1'b0, 1'b0);
`endif

    // Reset in the middle of a fetch.
    centerX = 8'd10;
    centerY = 8'd10;
    start   = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 1; k <= 8; k++) @(negedge clock);
    nReset = 1'b0;
    #1;
    chk("midreset busy", int'(busy), 0);
    chk("midreset sramRe", int'(sramRe), 0);
    chk("midreset sramAddr", int'(sramAddr), 0);
    chk("midreset regWe", int'(regWe), 0);
    chk("midreset regAddr", int'(regAddr), 0);
    chk("midreset readen", int'(readen), 0);
    idle_cycles(3, 1'b0);
    nReset = 1'b1;
    idle_cycles(2, 1'b0);
    do_fetch(20, 5, 1'b0, 1'b0);
    chk("after reset addr", obs_addr[0], 340);

    // Random in-range centers with the inputs wiggling during the fetch.
    for (int r = 0; r < 30; r++) begin
      do_fetch(int'($urandom_range(3, 60)), int'($urandom_range(3, 60)),
               1'b1, r[0]);
      if (r % 7 == 3) idle_cycles(int'($urandom_range(1, 4)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
